adc_usb_capture: RTL and testbench
==================================

Name: adc_usb_capture

Overview:
Capture engine for the ADC-to-host direction. It complements the host-to-DAC path that unpacks 32-bit USB words into 8-bit samples.
- Takes signed 8-bit ADC samples, applies an optional trigger and decimation, and captures a programmed number of samples.
- Packs 4 samples per 32-bit word and pushes the words into the USB write FIFO, honouring its full flag.
- Sits between the ADC input channel and the USB write path. It is controlled by channel registers.

Parameters:
- MAX_DECIM_W, 16: width of the decimation ratio field.
- OVF_W, 16: width of the saturating overflow counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- cfg_start  in  1  single-cycle pulse; arms a capture.
- cfg_abort  in  1  single-cycle pulse; ends the capture early.
- cfg_trig_mode  in  2  0 = immediate, 1 = rising threshold, 2 = falling threshold, 3 = reserved (treated as 0).
- cfg_trig_level  in  8  signed trigger threshold.
- cfg_decim  in  MAX_DECIM_W  keep 1 of every (cfg_decim+1) valid samples.
- cfg_length  in  32  number of samples to capture; 0 = continuous until abort.
- adc_data  in  8  signed ADC sample.
- adc_valid  in  1  adc_data is valid this cycle.
- usb_wr_data  out  32  packed word; the first sample occupies bits [7:0].
- usb_wr_data_valid  out  1  one-cycle write strobe to the USB FIFO.
- usb_wr_full  in  1  the USB write FIFO is full.
- busy  out  1  high in ARMED, CAPTURE and FLUSH.
- done  out  1  high in DONE.
- overflow_count  out  OVF_W  number of dropped words; saturates.
- sample_count  out  32  number of accepted samples in the current or last capture.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, and the lane index and decimation counter are 0.
- States: IDLE, ARMED, CAPTURE, FLUSH, DONE.
- Start:
  - cfg_start in IDLE or DONE latches all cfg_* inputs.
  - It also clears sample_count, overflow_count, the lane index and the previous-sample-valid flag, then moves to ARMED.
  - cfg_start in any other state is ignored.
  - cfg_* changes while busy have no effect.
- Abort:
  - cfg_abort in ARMED goes to DONE.
  - cfg_abort in CAPTURE goes to FLUSH.
  - If cfg_abort and cfg_start are asserted in the same cycle, abort wins; in IDLE or DONE the pair is a no-op.
- ARMED, trigger mode 0: the first adc_valid sample is the trigger sample.
- ARMED, trigger modes 1 and 2:
  - The trigger compares the previous valid sample (prev) with the current one, both signed.
  - Rising: prev < level AND cur >= level. Falling: prev > level AND cur <= level.
  - The first valid sample after arming only loads prev and cannot trigger.
- Trigger sample:
  - It is accepted (packed and counted), and the state moves to CAPTURE.
  - The decimation counter is set to 1, or stays 0 if cfg_decim==0.
- CAPTURE, per adc_valid:
  - If the decimation counter == 0, the sample is accepted.
  - The counter advances modulo cfg_decim+1.
  - adc_valid low: nothing changes.
- Packing:
  - An accepted sample is written to lane[idx], bits [8*idx+7 : 8*idx], and idx increments.
  - On the 4th lane the word is issued on the following cycle: usb_wr_data_valid=1 for exactly one cycle. Latency is 1 clk from the adc_valid of the 4th sample.
  - The word register is zero-filled after each issue.
- Overflow:
  - If usb_wr_full==1 in the issue cycle, the word is dropped and usb_wr_data_valid stays 0.
  - overflow_count increments, saturating at 2^OVF_W-1.
  - There is no retry and no stall; the data loss is intended and visible.
- Length:
  - sample_count increments on every accepted sample, including samples in dropped words.
  - When an accept makes sample_count == cfg_length (cfg_length != 0), the state moves to FLUSH.
  - If cfg_length==0, the capture runs until abort, and sample_count wraps at 2^32.
- FLUSH:
  - If idx != 0, the partial word is issued with the unused upper lanes set to 0, under the same full/drop rule. Then the state moves to DONE.
  - If idx == 0 (any full word already issued), the state moves to DONE the next cycle.
  - adc_valid is ignored.
- DONE:
  - done=1 and busy=0.
  - sample_count and overflow_count hold until the next cfg_start.
- Reset mid-capture: any in-progress partial word is discarded and no strobe is emitted.

Decomposition:
- Package adc_capture_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE, FLUSH, DONE);
  - the trigger mode localparams TRIG_IMM, TRIG_RISE, TRIG_FALL;
  - LANES=4 and SAMPLE_W=8.
- One sub-module, sample_packer_4x8:
  - inputs: lane accept, flush request and clear;
  - outputs: word and word-issue strobe;
  - it owns idx, the word register and the zero-fill.
- The FSM, trigger, decimation and counters stay in the top module.

Test Plan:
1. Mode 0, decim 0, length 8; feed samples 0x01..0x08 continuously, with full=0 -> two strobes with words 0x04030201 then 0x08070605; done=1, sample_count=8, overflow_count=0.
2. Mode 1, level 0x10; feed 0x00, 0x05, 0x20, 0x30, 0x40, 0x50 (length 4) -> first word 0x50403020; the sample 0x05 does not trigger.
3. Decim 2, length 4, mode 0; feed 0x00..0x0B -> single word 0x09060300.
4. Length 6, with usb_wr_full held at 1 during the first issue cycle -> first word dropped, overflow_count=1; second (flush) word 0x0000_0605 (lanes 0-1 = 0x05, 0x06, upper lanes zero) is written.
5. Length 0, abort after 5 samples 0xA1..0xA5 -> words 0xA4A3A2A1 and 0x000000A5, then done=1 and sample_count=5.
6. Pull reset low mid-capture after 2 samples -> all outputs 0 next cycle, no strobe; a subsequent start captures cleanly from lane 0.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC-to-USB capture engine.
package adc_capture_pkg;
   localparam int LANES    = 4;
   localparam int SAMPLE_W = 8;
   localparam int WORD_W   = LANES * SAMPLE_W;
   localparam int IDX_W    = $clog2(LANES);

   localparam logic [1:0] TRIG_IMM  = 2'd0;
   localparam logic [1:0] TRIG_RISE = 2'd1;
   localparam logic [1:0] TRIG_FALL = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_FLUSH,
      ST_DONE
   } cap_state_e;
endpackage

// File: rtl/sample_packer_4x8.sv
// Packs accepted 8-bit samples into 32-bit words, first sample in the low
// byte. A completed (or flushed partial) word is held in the output register
// for exactly one cycle with issue high, then the register is zero-filled.
module sample_packer_4x8
   import adc_capture_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                accept,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                flush,
   input  logic                clear,
   output logic [WORD_W-1:0]   word,
   output logic                issue
);
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] acc_next;

   // Accumulator with the incoming sample dropped into the current lane.
   always_comb begin
      acc_next = acc;
      acc_next[int'(idx)*SAMPLE_W +: SAMPLE_W] = sample;
   end

   // Lane index, accumulator and output word register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx   <= '0;
         acc   <= '0;
         word  <= '0;
         issue <= 1'b0;
      end else begin
         issue <= 1'b0;
         if (issue) word <= '0;
         if (clear) begin
            idx <= '0;
            acc <= '0;
         end else if (accept) begin
            if (idx == IDX_W'(LANES - 1)) begin
               word  <= acc_next;
               issue <= 1'b1;
               acc   <= '0;
               idx   <= '0;
            end else begin
               acc <= acc_next;
               idx <= idx + 1'b1;
            end
         end else if (flush && idx != '0) begin
            // Upper lanes are already zero because acc is zero-filled.
            word  <= acc;
            issue <= 1'b1;
            acc   <= '0;
            idx   <= '0;
         end
      end
   end
endmodule

// File: rtl/adc_usb_capture.sv
// ADC-to-host capture engine: trigger, decimation, length control and
// overflow accounting around a 4x8 sample packer feeding the USB write FIFO.
// Handshake: the USB side has no ready; a word strobe is valid for one cycle
// and is dropped (and counted) when usb_wr_full is high in that cycle.
module adc_usb_capture
   import adc_capture_pkg::*;
#(
   parameter int MAX_DECIM_W = 16,
   parameter int OVF_W       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_start,
   input  logic                   cfg_abort,
   input  logic [1:0]             cfg_trig_mode,
   input  logic [7:0]             cfg_trig_level,
   input  logic [MAX_DECIM_W-1:0] cfg_decim,
   input  logic [31:0]            cfg_length,
   input  logic [7:0]             adc_data,
   input  logic                   adc_valid,
   output logic [31:0]            usb_wr_data,
   output logic                   usb_wr_data_valid,
   input  logic                   usb_wr_full,
   output logic                   busy,
   output logic                   done,
   output logic [OVF_W-1:0]       overflow_count,
   output logic [31:0]            sample_count
);
   cap_state_e state, state_next;

   logic [1:0]             trig_mode_q;
   logic signed [7:0]      trig_level_q;
   logic [MAX_DECIM_W-1:0] decim_q;
   logic [31:0]            length_q;
   logic [MAX_DECIM_W-1:0] decim_cnt;
   logic signed [7:0]      prev_q;
   logic                   prev_valid;
   logic signed [7:0]      cur;
   logic                   start_ok, trig_hit, accept, length_hit, word_issue;

   assign cur      = adc_data;
   assign start_ok = cfg_start && !cfg_abort && (state == ST_IDLE || state == ST_DONE);

   // Trigger condition evaluated on the current valid sample.
   always_comb begin
      trig_hit = 1'b0;
      case (trig_mode_q)
         TRIG_IMM:  trig_hit = 1'b1;
         TRIG_RISE: trig_hit = prev_valid && (prev_q < trig_level_q) && (cur >= trig_level_q);
         TRIG_FALL: trig_hit = prev_valid && (prev_q > trig_level_q) && (cur <= trig_level_q);
         default:   trig_hit = 1'b1;
      endcase
   end

   // Abort takes priority over a sample arriving in the same cycle.
   assign accept = adc_valid && !cfg_abort &&
                   ((state == ST_ARMED && trig_hit) ||
                    (state == ST_CAPTURE && decim_cnt == '0));
   assign length_hit = accept && (length_q != 32'd0) && (sample_count + 32'd1 == length_q);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE: if (start_ok) state_next = ST_ARMED;
         ST_ARMED: begin
            if (cfg_abort)   state_next = ST_DONE;
            else if (accept) state_next = length_hit ? ST_FLUSH : ST_CAPTURE;
         end
         ST_CAPTURE: if (cfg_abort || length_hit) state_next = ST_FLUSH;
         ST_FLUSH: state_next = ST_DONE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // State-decoded status outputs.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ST_ARMED, ST_CAPTURE, ST_FLUSH: busy = 1'b1;
         ST_DONE:                        done = 1'b1;
         default: ;
      endcase
   end

   // Configuration latch, trigger history, decimation and counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         trig_mode_q    <= '0;
         trig_level_q   <= '0;
         decim_q        <= '0;
         length_q       <= '0;
         decim_cnt      <= '0;
         prev_q         <= '0;
         prev_valid     <= 1'b0;
         sample_count   <= '0;
         overflow_count <= '0;
      end else if (start_ok) begin
         trig_mode_q    <= cfg_trig_mode;
         trig_level_q   <= cfg_trig_level;
         decim_q        <= cfg_decim;
         length_q       <= cfg_length;
         decim_cnt      <= '0;
         prev_valid     <= 1'b0;
         sample_count   <= '0;
         overflow_count <= '0;
      end else begin
         if (state == ST_ARMED && adc_valid && !cfg_abort) begin
            prev_q     <= cur;
            prev_valid <= 1'b1;
            if (trig_hit) decim_cnt <= (decim_q == '0) ? '0 : MAX_DECIM_W'(1);
         end
         if (state == ST_CAPTURE && adc_valid && !cfg_abort)
            decim_cnt <= (decim_cnt == decim_q) ? '0 : decim_cnt + 1'b1;
         if (accept) sample_count <= sample_count + 32'd1;
         if (word_issue && usb_wr_full && overflow_count != '1)
            overflow_count <= overflow_count + 1'b1;
      end
   end

   sample_packer_4x8 u_packer (
      .clk    (clk),
      .reset  (reset),
      .accept (accept),
      .sample (adc_data),
      .flush  (state == ST_FLUSH),
      .clear  (start_ok),
      .word   (usb_wr_data),
      .issue  (word_issue)
   );

   assign usb_wr_data_valid = word_issue && !usb_wr_full;
endmodule

// File: tb/tb_adc_usb_capture.sv
// Bench for adc_usb_capture: per-cycle stimulus tables, a sample-stream
// reference model and a word scoreboard.
module tb_adc_usb_capture;
   localparam int MAXC = 80;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_start = 1'b0, cfg_abort = 1'b0;
   logic [1:0]  cfg_trig_mode = '0;
   logic [7:0]  cfg_trig_level = '0;
   logic [15:0] cfg_decim = '0;
   logic [31:0] cfg_length = '0;
   logic [7:0]  adc_data = '0;
   logic        adc_valid = 1'b0;
   logic [31:0] usb_wr_data;
   logic        usb_wr_data_valid;
   logic        usb_wr_full = 1'b0;
   logic        busy, done;
   logic [1:0]  overflow_count;
   logic [31:0] sample_count;

   // clock / reset
   always #5 clk = ~clk;

   adc_usb_capture #(.MAX_DECIM_W(16), .OVF_W(2)) dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_trig_mode(cfg_trig_mode), .cfg_trig_level(cfg_trig_level),
      .cfg_decim(cfg_decim), .cfg_length(cfg_length), .adc_data(adc_data),
      .adc_valid(adc_valid), .usb_wr_data(usb_wr_data),
      .usb_wr_data_valid(usb_wr_data_valid), .usb_wr_full(usb_wr_full),
      .busy(busy), .done(done), .overflow_count(overflow_count),
      .sample_count(sample_count));

   // stimulus tables, indexed by cycle (cycle 0 carries the start pulse)
   logic       v_a [MAXC];
   logic [7:0] d_a [MAXC];
   logic       f_a [MAXC];
   int         abort_at;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // word monitor
   always @(negedge clk) if (usb_wr_data_valid) got_q.push_back(usb_wr_data);

   task automatic clear_stim();
      for (int i = 0; i < MAXC; i++) begin
         v_a[i] = 1'b0; d_a[i] = 8'h00; f_a[i] = 1'b0;
      end
      abort_at = -1;
   endtask

   // Reference: walk the valid-sample stream, find the trigger, keep every
   // (decim+1)-th sample, group into 4-byte words. A full word goes out one
   // cycle after its 4th sample, a partial word two cycles after the
   // terminating accept/abort; it is lost if full is high in that cycle.
   task automatic model(input int mode, input logic [7:0] level, input int decim,
                        input int len, input int n, output int exp_cnt, output int exp_ovf);
      bit armed, have_prev, trig, take, fin;
      logic signed [7:0] prev, cur, lvl;
      int since, cnt, drops, lane;
      logic [31:0] w;
      exp_q.delete();
      armed = 1; have_prev = 0; fin = 0; since = 0; cnt = 0; drops = 0; lane = 0;
      w = '0; lvl = level; prev = '0;
      for (int i = 1; i < n && !fin; i++) begin
         if (i == abort_at) begin
            if (!armed && lane != 0) begin
               if (f_a[i+2]) drops++; else exp_q.push_back(w);
            end
            fin = 1;
         end else if (v_a[i]) begin
            cur = d_a[i];
            take = 0;
            if (armed) begin
               case (mode)
                  1: trig = have_prev && (prev < lvl) && (cur >= lvl);
                  2: trig = have_prev && (prev > lvl) && (cur <= lvl);
                  default: trig = 1;
               endcase
               prev = cur; have_prev = 1;
               if (trig) begin armed = 0; since = 0; take = 1; end
            end else begin
               since++;
               take = (since % (decim + 1)) == 0;
            end
            if (take) begin
               w[8*lane +: 8] = cur;
               lane++; cnt++;
               if (lane == 4) begin
                  if (f_a[i+1]) drops++; else exp_q.push_back(w);
                  w = '0; lane = 0;
               end
               if (len != 0 && cnt == len) begin
                  if (lane != 0) begin
                     if (f_a[i+2]) drops++; else exp_q.push_back(w);
                  end
                  fin = 1;
               end
            end
         end
      end
      exp_cnt = cnt;
      exp_ovf = (drops > 3) ? 3 : drops;
   endtask

   // driver: plays the tables, garbling cfg_* while busy, then scores
   task automatic run(input string name, input int mode, input logic [7:0] level,
                      input int decim, input int len, input int n);
      int exp_cnt, exp_ovf, m;
      model(mode, level, decim, len, n, exp_cnt, exp_ovf);
      got_q.delete();
      for (int c = 0; c < n + 4; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            cfg_trig_mode  = 2'(mode);
            cfg_trig_level = level;
            cfg_decim      = 16'(decim);
            cfg_length     = 32'(len);
         end else begin
            cfg_trig_mode  = 2'($urandom_range(0, 3));
            cfg_trig_level = 8'($urandom);
            cfg_decim      = 16'($urandom_range(0, 5));
            cfg_length     = 32'($urandom_range(0, 9));
         end
         cfg_start   = (c == 0);
         cfg_abort   = (c == abort_at);
         adc_valid   = v_a[c];
         adc_data    = d_a[c];
         usb_wr_full = f_a[c];
         if (c == 1) check({name, ".busy_armed"}, 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      cfg_start = 0; cfg_abort = 0; adc_valid = 0; usb_wr_full = 0;
      @(negedge clk);
      check({name, ".done"}, 32'(done), 32'd1);
      check({name, ".busy"}, 32'(busy), 32'd0);
      check({name, ".sample_count"}, sample_count, 32'(exp_cnt));
      check({name, ".overflow"}, 32'(overflow_count), 32'(exp_ovf));
      check({name, ".n_words"}, 32'(got_q.size()), 32'(exp_q.size()));
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int k = 0; k < m; k++)
         check($sformatf("%s.word%0d", name, k), got_q[k], exp_q[k]);
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".data"}, usb_wr_data, 32'd0);
      check({name, ".valid"}, 32'(usb_wr_data_valid), 32'd0);
      check({name, ".busy"}, 32'(busy), 32'd0);
      check({name, ".done"}, 32'(done), 32'd0);
      check({name, ".ovf"}, 32'(overflow_count), 32'd0);
      check({name, ".cnt"}, sample_count, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      reset = 1'b1;

      // mode 0, decim 0, length 8
      clear_stim();
      for (int i = 1; i <= 8; i++) begin v_a[i] = 1; d_a[i] = 8'(i); end
      run("t1_basic", 0, 8'h00, 0, 8, 20);

      // rising trigger at 0x10; 0x05 must not trigger
      clear_stim();
      begin
         logic [7:0] s [6];
         s = '{8'h00, 8'h05, 8'h20, 8'h30, 8'h40, 8'h50};
         for (int i = 0; i < 6; i++) begin v_a[i+1] = 1; d_a[i+1] = s[i]; end
      end
      run("t2_rise", 1, 8'h10, 0, 4, 20);

      // decimation by 3
      clear_stim();
      for (int i = 0; i < 12; i++) begin v_a[i+1] = 1; d_a[i+1] = 8'(i); end
      run("t3_decim", 0, 8'h00, 2, 4, 20);

      // first issue dropped, partial flush word survives
      clear_stim();
      for (int i = 1; i <= 6; i++) begin v_a[i] = 1; d_a[i] = 8'(i); end
      f_a[5] = 1;
      run("t4_full", 0, 8'h00, 0, 6, 20);

      // continuous, abort after 5 samples
      clear_stim();
      for (int i = 1; i <= 5; i++) begin v_a[i] = 1; d_a[i] = 8'(8'hA0 + i); end
      abort_at = 7;
      run("t5_abort", 0, 8'h00, 0, 0, 14);

      // overflow counter saturation (2-bit counter, 6 drops)
      clear_stim();
      for (int i = 1; i <= 24; i++) begin v_a[i] = 1; d_a[i] = 8'(i); end
      for (int i = 0; i < MAXC; i++) f_a[i] = 1;
      run("t7_sat", 0, 8'h00, 0, 24, 34);

      // reset mid-capture after 2 samples
      got_q.delete();
      @(posedge clk); #1;
      cfg_start = 1; cfg_trig_mode = 0; cfg_decim = 0; cfg_length = 0;
      @(posedge clk); #1;
      cfg_start = 0; adc_valid = 1; adc_data = 8'h11;
      @(posedge clk); #1;
      adc_data = 8'h22;
      @(posedge clk); #1;
      adc_valid = 0; reset = 0;
      @(posedge clk); #1;
      check_all_zero("t6_reset");
      reset = 1;
      repeat (4) @(posedge clk);
      #1 check("t6_reset.no_strobe", 32'(got_q.size()), 32'd0);

      clear_stim();
      for (int i = 1; i <= 8; i++) begin v_a[i] = 1; d_a[i] = 8'(8'h30 + i); end
      run("t6_restart", 0, 8'h00, 0, 8, 20);

      // randomized captures
      for (int r = 0; r < 12; r++) begin
         clear_stim();
         for (int i = 1; i < 64; i++) begin
            v_a[i] = ($urandom_range(0, 3) != 0);
            d_a[i] = 8'($urandom);
            f_a[i] = ($urandom_range(0, 3) == 0);
         end
         abort_at = $urandom_range(20, 57);
         v_a[abort_at] = 0;
         run($sformatf("rnd%0d", r), $urandom_range(0, 3), 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 14), 60);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
